mem_port_arbiter: RTL

Arbitrates the processor's single external memory port between the instruction-fetch requester and the load/store (data) requester. Data accesses win by default. A starvation counter forces a fetch grant after `STARVE_LIMIT` consecutive fetch losses. One transaction is in flight at a time; the memory side is a req/ack handshake of arbitrary latency. Sits between the fetch/MEM stages of `advanced_processor` and the `inst_in`/`data_in` memory interface.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_picker.sv | 17 +
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the external memory port arbiter.
// Holds the FSM state type and the stall counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } mem_arb_state_t;

  localparam int MEM_ARB_STALL_CNT_W = 32;

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational winner select.
// Data wins unless only fetch asks or fetch is starved.
module mem_arb_picker (
  input  logic if_req,
  input  logic dm_req,
  input  logic starve,
  output logic sel_if,
  output logic sel_dm
);

  // fetch wins when starved or uncontested, else data
  always_comb begin
    sel_if = if_req & (starve | ~dm_req);
    sel_dm = dm_req & ~sel_if;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory port between
// instruction fetch and load/store, one transaction in flight.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [MEM_ARB_STALL_CNT_W-1:0] fetch_stall_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam int CW = MEM_ARB_STALL_CNT_W;

  mem_arb_state_t state_q, state_d;
  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [CW-1:0] fetch_stall_count_q;
  logic [CW-1:0] fetch_stall_count_d;
  logic if_rvalid_q, if_rvalid_d;
  logic dm_rvalid_q, dm_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

  logic starve, sel_if, sel_dm, idle_en;

  assign starve = (starve_cnt_q == STARVE_MAX);

  mem_arb_picker u_picker (
    .if_req (if_req),
    .dm_req (dm_req),
    .starve (starve),
    .sel_if (sel_if),
    .sel_dm (sel_dm)
  );

  // grants only from IDLE and never while reset is held
  always_comb begin
    idle_en = rst & (state_q == IDLE);
    if_gnt  = idle_en & sel_if;
    dm_gnt  = idle_en & sel_dm;
  end

  // FSM, memory request registers and read-data capture
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    starve_cnt_d = starve_cnt_q;
    if_rvalid_d  = 1'b0;
    dm_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (if_gnt) begin
          state_d      = BUSY_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
        end else if (dm_gnt) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req && !starve)
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end
      end
      BUSY_DM: begin
        if (mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = mem_we_q ? '0 : mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // saturating count of cycles fetch waited without a grant
  always_comb begin
    fetch_stall_count_d = fetch_stall_count_q;
    if (if_req && !if_gnt && fetch_stall_count_q != '1)
      fetch_stall_count_d = fetch_stall_count_q + CW'(1);
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q             <= IDLE;
      mem_req_q           <= 1'b0;
      mem_we_q            <= 1'b0;
      mem_addr_q          <= '0;
      mem_wdata_q         <= '0;
      starve_cnt_q        <= '0;
      fetch_stall_count_q <= '0;
      if_rvalid_q         <= 1'b0;
      dm_rvalid_q         <= 1'b0;
      if_rdata_q          <= '0;
      dm_rdata_q          <= '0;
    end else begin
      state_q             <= state_d;
      mem_req_q           <= mem_req_d;
      mem_we_q            <= mem_we_d;
      mem_addr_q          <= mem_addr_d;
      mem_wdata_q         <= mem_wdata_d;
      starve_cnt_q        <= starve_cnt_d;
      fetch_stall_count_q <= fetch_stall_count_d;
      if_rvalid_q         <= if_rvalid_d;
      dm_rvalid_q         <= dm_rvalid_d;
      if_rdata_q          <= if_rdata_d;
      dm_rdata_q          <= dm_rdata_d;
    end
  end

  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign if_rvalid         = if_rvalid_q;
  assign dm_rvalid         = dm_rvalid_q;
  assign if_rdata          = if_rdata_q;
  assign dm_rdata          = dm_rdata_q;
  assign fetch_stall_count = fetch_stall_count_q;

endmodule
